vga_scanout: RTL and testbench

//  Read side of the VGA frame buffer. The masking pipeline writes 12-bit RGB pixels into the frame buffer.

---
 rtl/vga_scanout_pkg.sv | 48 ++++
 rtl/vga_scanout_timing_gen.sv | 113 +++++++++++
 rtl/vga_scanout.sv | 138 +++++++++++++
 tb/tb_vga_scanout.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_scanout_pkg.sv
// Shared timing defaults, widths and pixel types for the VGA read side of the frame buffer.
package vga_scanout_pkg;

  // 640x480@60 timing defaults, in pixel ticks (horizontal) and lines (vertical).
  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam int unsigned DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // 50 MHz system clock divided down to the 25 MHz pixel rate.
  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_RD_LATENCY = 1;

  // Frame buffer geometry: each stored pixel covers a 2x2 block on screen.
  localparam int unsigned FB_ROWS = 240;
  localparam int unsigned FB_COLS = 320;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned COL_W = 9;
  localparam int unsigned ROW_W = 8;
  localparam int unsigned PIX_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Colour is forced to black outside the visible window.
  function automatic rgb_t blank_rgb(input logic visible, input pixel_t pix);
    rgb_t res;
    res = '0;
    if (visible) begin
      res = rgb_t'(pix);
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_scanout_timing_gen.sv
// Raster timing for the scanout: pixel-tick divider, h/v counters, raw sync, display enable,
// frame-start pulse and vblank level.
module vga_scanout_timing_gen
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tick,
  output logic             de,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic [COL_W-1:0] col_addr,
  output logic [ROW_W-1:0] row_addr,
  output logic             frame_start,
  output logic             vblank
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam cnt_t H_LAST = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_LAST = CNT_W'(V_TOTAL - 1);
  localparam cnt_t H_VIS  = CNT_W'(H_ACTIVE);
  localparam cnt_t V_VIS  = CNT_W'(V_ACTIVE);
  localparam cnt_t HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Both totals must fit the 10-bit raster counters.
  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_cnt_width_check
    $error("vga_scanout_timing_gen: H_TOTAL/V_TOTAL exceed counter width");
  end

  if (CLK_DIV == 0) begin : g_clk_div_check
    $error("vga_scanout_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt;
  cnt_t             h_cnt;
  cnt_t             v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             at_origin;

  assign tick      = (div_cnt == DIV_LAST);
  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  // Divide the system clock down to one pixel tick every CLK_DIV clks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster position: h wraps at the end of each line and carries into v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Decode the current raster position; sync pulses are active low.
  always_comb begin
    de       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_raw   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    // 2x2 scaling: drop the LSB of each screen coordinate.
    col_addr = h_cnt[CNT_W-1:1];
    row_addr = v_cnt[ROW_W:1];
  end

  // Writer-side markers; frame_start lasts one clk, vblank is a level held across ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= tick && at_origin;
      if (tick) begin
        vblank <= (v_cnt >= V_VIS);
      end
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: reads the 320x240 frame buffer with 2x2 scaling and drives 640x480@60 RGB and
// sync pins through a two-stage pipeline so colour and sync leave on the same tick.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] fb_data,
  output logic [ROW_W-1:0] fb_row,
  output logic [COL_W-1:0] fb_col,
  output logic             fb_rd_en,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             frame_start,
  output logic             vblank
);

  // Read data is sampled one tick after the address, so it must settle within CLK_DIV clks.
  if (RD_LATENCY >= CLK_DIV) begin : g_rd_latency_check
    $error("vga_scanout: RD_LATENCY must be less than CLK_DIV");
  end

  // The scaled visible window must lie inside the frame buffer.
  if (((H_ACTIVE / 2) > FB_COLS) || ((V_ACTIVE / 2) > FB_ROWS)) begin : g_fb_size_check
    $error("vga_scanout: visible area larger than the frame buffer");
  end

  logic             tick;
  logic             de;
  logic             hs_raw;
  logic             vs_raw;
  logic [COL_W-1:0] col_addr;
  logic [ROW_W-1:0] row_addr;

  vga_scanout_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .de          (de),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .col_addr    (col_addr),
    .row_addr    (row_addr),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  logic   de_s0;
  logic   hs_s0;
  logic   vs_s0;
  logic   de_s1;
  logic   hs_s1;
  logic   vs_s1;
  pixel_t pix_s1;
  rgb_t   rgb_q;

  // Stage 0: issue the frame buffer read for visible pixels and capture the raw strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_row   <= '0;
      fb_col   <= '0;
      fb_rd_en <= 1'b0;
      de_s0    <= 1'b0;
      hs_s0    <= 1'b1;
      vs_s0    <= 1'b1;
    end else begin
      // Single-clk strobe, cleared on the clk after the tick.
      fb_rd_en <= tick && de;
      if (tick) begin
        de_s0 <= de;
        hs_s0 <= hs_raw;
        vs_s0 <= vs_raw;
        // The address holds through blanking so the RAM sees no spurious change.
        if (de) begin
          fb_col <= col_addr;
          fb_row <= row_addr;
        end
      end
    end
  end

  // Stage 1: sample the read data and delay the strobes to stay aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_s1 <= '0;
      de_s1  <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
    end else if (tick) begin
      pix_s1 <= fb_data;
      de_s1  <= de_s0;
      hs_s1  <= hs_s0;
      vs_s1  <= vs_s0;
    end
  end

  // Output stage: registered pins, colour blanked whenever the pixel is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (tick) begin
      rgb_q  <= blank_rgb(de_s1, pix_s1);
      vga_hs <= hs_s1;
      vga_vs <= vs_s1;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-raster instance checked tick by tick against a scoreboard,
// plus a default 640x480 instance checked at line-level landmarks.
module tb_vga_scanout;

  localparam int unsigned HA   = 16;
  localparam int unsigned HFP  = 4;
  localparam int unsigned HSY  = 6;
  localparam int unsigned HBP  = 6;
  localparam int unsigned VA   = 8;
  localparam int unsigned VFP  = 2;
  localparam int unsigned VSY  = 2;
  localparam int unsigned VBP  = 3;
  localparam int unsigned CDIV = 2;
  localparam int unsigned HT   = HA + HFP + HSY + HBP;
  localparam int unsigned VT   = VA + VFP + VSY + VBP;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } pins_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [11:0] s_fb_data = '0;
  logic [7:0]  s_row;
  logic [8:0]  s_col;
  logic        s_rd, s_hs, s_vs, s_fs, s_vb;
  logic [3:0]  s_r, s_g, s_b;
  logic [11:0] s_rgb;

  logic [11:0] f_fb_data = '0;
  logic [7:0]  f_row;
  logic [8:0]  f_col;
  logic        f_rd, f_hs, f_vs, f_fs, f_vb;
  logic [3:0]  f_r, f_g, f_b;
  logic [11:0] f_rgb;

  int     checks = 0;
  int     failures = 0;
  longint clk_count = 0;
  pins_t  sb_q[$];

  assign s_rgb = {s_r, s_g, s_b};
  assign f_rgb = {f_r, f_g, f_b};

  always #5 clk = ~clk;

  always @(posedge clk) clk_count <= clk_count + 1;

  // Frame buffer models: one-clk read latency, data encodes the address.
  always @(posedge clk) s_fb_data <= {s_row[3:0], s_col[3:0], 4'hA};
  always @(posedge clk) f_fb_data <= {f_row[3:0], f_col[3:0], 4'hA};

  vga_scanout #(
    .H_ACTIVE   (HA),
    .H_FP       (HFP),
    .H_SYNC     (HSY),
    .H_BP       (HBP),
    .V_ACTIVE   (VA),
    .V_FP       (VFP),
    .V_SYNC     (VSY),
    .V_BP       (VBP),
    .CLK_DIV    (CDIV),
    .RD_LATENCY (1)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fb_data     (s_fb_data),
    .fb_row      (s_row),
    .fb_col      (s_col),
    .fb_rd_en    (s_rd),
    .vga_r       (s_r),
    .vga_g       (s_g),
    .vga_b       (s_b),
    .vga_hs      (s_hs),
    .vga_vs      (s_vs),
    .frame_start (s_fs),
    .vblank      (s_vb)
  );

  vga_scanout u_dut_full (
    .clk         (clk),
    .rst_n       (rst_n),
    .fb_data     (f_fb_data),
    .fb_row      (f_row),
    .fb_col      (f_col),
    .fb_rd_en    (f_rd),
    .vga_r       (f_r),
    .vga_g       (f_g),
    .vga_b       (f_b),
    .vga_hs      (f_hs),
    .vga_vs      (f_vs),
    .frame_start (f_fs),
    .vblank      (f_vb)
  );

  function automatic logic [11:0] exp_pix(input int h, input int v, input int ha, input int va);
    if ((h < ha) && (v < va)) begin
      return {4'((v / 2) % 16), 4'((h / 2) % 16), 4'hA};
    end
    return 12'h000;
  endfunction

  // Advance to just after the next pixel-tick edge.
  task automatic adv_tick();
    repeat (CDIV) @(posedge clk);
    #1;
  endtask

  // Hold reset for n clks and release on a falling edge; the next rising edge is clk 1.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({s_hs, s_vs, s_rgb, s_rd, s_fs, s_vb} !== {1'b1, 1'b1, 12'h000, 3'b000}) begin
        failures++;
        $display("FAIL reset_small clk=%0d hs=%b vs=%b rgb=%h rd=%b fs=%b vb=%b required 1 1 000 0 0 0",
                 i, s_hs, s_vs, s_rgb, s_rd, s_fs, s_vb);
      end
      checks++;
      if ({f_hs, f_vs, f_rgb, f_rd, f_fs, f_vb} !== {1'b1, 1'b1, 12'h000, 3'b000}) begin
        failures++;
        $display("FAIL reset_full clk=%0d hs=%b vs=%b rgb=%h rd=%b fs=%b vb=%b required 1 1 000 0 0 0",
                 i, f_hs, f_vs, f_rgb, f_rd, f_fs, f_vb);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    adv_tick();
    checks++;
    if ({s_fs, f_fs} !== 2'b11) begin
      failures++;
      $display("FAIL first_frame_start got small=%b full=%b required 1 1", s_fs, f_fs);
    end
    checks++;
    if ({s_rd, s_row, s_col} !== {1'b1, 8'd0, 9'd0}) begin
      failures++;
      $display("FAIL first_read got rd=%b row=%0d col=%0d required 1 0 0", s_rd, s_row, s_col);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({s_fs, s_rd} !== 2'b00) begin
      failures++;
      $display("FAIL first_pulse_width got fs=%b rd=%b required 0 0", s_fs, s_rd);
    end
  endtask

  task automatic test_free_run();
    int     h, v;
    logic   e_de;
    logic [8:0] m_col;
    logic [7:0] m_row;
    pins_t  e_pins, got;
    int     hs_run, vs_run, last_hs_fall;
    logic   prev_hs, prev_vs;
    longint fs_prev;
    m_col = '0;
    m_row = '0;
    hs_run = 0;
    vs_run = 0;
    last_hs_fall = -1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    fs_prev = -1;
    do_reset(10);
    sb_q.delete();
    sb_q.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
    sb_q.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
    for (int n = 0; n < int'(2 * HT * VT + 4); n++) begin
      h = n % HT;
      v = (n / HT) % VT;
      for (int c = 0; c < int'(CDIV) - 1; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if ({s_fs, s_rd} !== 2'b00) begin
          failures++;
          $display("FAIL pulse_width n=%0d got fs=%b rd=%b required 0 0", n, s_fs, s_rd);
        end
      end
      @(posedge clk);
      #1;
      e_de = (h < int'(HA)) && (v < int'(VA));
      if (e_de) begin
        m_col = 9'(h / 2);
        m_row = 8'(v / 2);
      end
      checks++;
      if ({s_fs, s_vb, s_rd} !== {(h == 0) && (v == 0), v >= int'(VA), e_de}) begin
        failures++;
        $display("FAIL markers h=%0d v=%0d got fs=%b vb=%b rd=%b required %b %b %b", h, v, s_fs,
                 s_vb, s_rd, (h == 0) && (v == 0), v >= int'(VA), e_de);
      end
      checks++;
      if ({s_row, s_col} !== {m_row, m_col}) begin
        failures++;
        $display("FAIL address h=%0d v=%0d got row=%0d col=%0d required %0d %0d", h, v, s_row,
                 s_col, m_row, m_col);
      end
      e_pins.rgb = exp_pix(h, v, HA, VA);
      e_pins.hs  = !((h >= int'(HA + HFP)) && (h < int'(HA + HFP + HSY)));
      e_pins.vs  = !((v >= int'(VA + VFP)) && (v < int'(VA + VFP + VSY)));
      sb_q.push_back(e_pins);
      got = '{rgb: s_rgb, hs: s_hs, vs: s_vs};
      e_pins = sb_q.pop_front();
      checks++;
      if (got !== e_pins) begin
        failures++;
        $display("FAIL pins n=%0d got rgb=%h hs=%b vs=%b required rgb=%h hs=%b vs=%b", n,
                 got.rgb, got.hs, got.vs, e_pins.rgb, e_pins.hs, e_pins.vs);
      end
      if (prev_hs && !s_hs) begin
        if (last_hs_fall >= 0) begin
          checks++;
          if (n - last_hs_fall != int'(HT)) begin
            failures++;
            $display("FAIL hs_period got=%0d required=%0d", n - last_hs_fall, HT);
          end
        end
        last_hs_fall = n;
      end
      if (!s_hs) hs_run++;
      else if (hs_run != 0) begin
        checks++;
        if (hs_run != int'(HSY)) begin
          failures++;
          $display("FAIL hs_width got=%0d required=%0d", hs_run, HSY);
        end
        hs_run = 0;
      end
      if (!s_vs) vs_run++;
      else if (vs_run != 0) begin
        checks++;
        if (vs_run != int'(VSY * HT)) begin
          failures++;
          $display("FAIL vs_width got=%0d required=%0d", vs_run, VSY * HT);
        end
        vs_run = 0;
      end
      if (s_fs) begin
        if (fs_prev >= 0) begin
          checks++;
          if (clk_count - fs_prev != longint'(HT * VT * CDIV)) begin
            failures++;
            $display("FAIL fs_period got=%0d required=%0d", clk_count - fs_prev, HT * VT * CDIV);
          end
        end
        fs_prev = clk_count;
      end
      prev_hs = s_hs;
      prev_vs = s_vs;
    end
    checks++;
    if (prev_vs !== 1'b1) begin
      failures++;
      $display("FAIL vs_end got=%b required=1", prev_vs);
    end
  endtask

  task automatic test_pixel();
    do_reset(10);
    for (int n = 0; n <= 104; n++) begin
      adv_tick();
      if (n == 102) begin
        checks++;
        if (s_rgb !== 12'h12A) begin
          failures++;
          $display("FAIL pixel_4_3 got=%h required=12a", s_rgb);
        end
      end
      if (n == 103) begin
        checks++;
        if (s_rgb !== 12'h12A) begin
          failures++;
          $display("FAIL pixel_5_3 got=%h required=12a", s_rgb);
        end
      end
      if (n == 104) begin
        checks++;
        if (s_rgb !== 12'h13A) begin
          failures++;
          $display("FAIL pixel_6_3 got=%h required=13a", s_rgb);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int nb;
    nb = (VA - 1) * HT + HA - 1;
    do_reset(10);
    for (int n = 0; n <= int'(HT * VT); n++) begin
      adv_tick();
      if (n == nb) begin
        checks++;
        if ({s_rd, s_col, s_row} !== {1'b1, 9'((HA - 1) / 2), 8'((VA - 1) / 2)}) begin
          failures++;
          $display("FAIL last_pixel got rd=%b col=%0d row=%0d required 1 %0d %0d", s_rd, s_col,
                   s_row, (HA - 1) / 2, (VA - 1) / 2);
        end
      end
      if (n == nb + 1) begin
        checks++;
        if ({s_rd, s_col, s_row, s_vb} !== {1'b0, 9'((HA - 1) / 2), 8'((VA - 1) / 2), 1'b0}) begin
          failures++;
          $display("FAIL after_last got rd=%b col=%0d row=%0d vb=%b required 0 %0d %0d 0", s_rd,
                   s_col, s_row, s_vb, (HA - 1) / 2, (VA - 1) / 2);
        end
      end
      if (n == int'(VA * HT)) begin
        checks++;
        if ({s_vb, s_rd} !== 2'b10) begin
          failures++;
          $display("FAIL vblank_rise got vb=%b rd=%b required 1 0", s_vb, s_rd);
        end
      end
      if (n == int'(HT * VT) - 1) begin
        checks++;
        if ({s_vb, s_rd, s_fs} !== 3'b100) begin
          failures++;
          $display("FAIL frame_end got vb=%b rd=%b fs=%b required 1 0 0", s_vb, s_rd, s_fs);
        end
      end
      if (n == int'(HT * VT)) begin
        checks++;
        if ({s_fs, s_vb, s_rd, s_col, s_row} !== {3'b101, 9'd0, 8'd0}) begin
          failures++;
          $display("FAIL wrap got fs=%b vb=%b rd=%b col=%0d row=%0d required 1 0 1 0 0", s_fs,
                   s_vb, s_rd, s_col, s_row);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(10);
    for (int n = 0; n <= int'(5 * HT + 10); n++) adv_tick();
    checks++;
    if (s_rgb !== 12'h24A) begin
      failures++;
      $display("FAIL pre_reset_rgb got=%h required=24a", s_rgb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_hs, s_vs, s_rgb, s_rd, s_fs, s_vb} !== {1'b1, 1'b1, 12'h000, 3'b000}) begin
      failures++;
      $display("FAIL async_reset_small got hs=%b vs=%b rgb=%h rd=%b fs=%b vb=%b required 1 1 000 0 0 0",
               s_hs, s_vs, s_rgb, s_rd, s_fs, s_vb);
    end
    checks++;
    if ({f_hs, f_vs, f_rgb, f_rd, f_fs, f_vb} !== {1'b1, 1'b1, 12'h000, 3'b000}) begin
      failures++;
      $display("FAIL async_reset_full got hs=%b vs=%b rgb=%h rd=%b fs=%b vb=%b required 1 1 000 0 0 0",
               f_hs, f_vs, f_rgb, f_rd, f_fs, f_vb);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n <= 658; n++) begin
      adv_tick();
      if (n == 0) begin
        checks++;
        if ({s_fs, f_fs, s_col, s_row} !== {2'b11, 9'd0, 8'd0}) begin
          failures++;
          $display("FAIL restart_origin got fs=%b/%b col=%0d row=%0d required 1/1 0 0", s_fs, f_fs,
                   s_col, s_row);
        end
      end
      if (n == int'(HA + HFP + 1) || n == int'(HA + HFP + 2)) begin
        checks++;
        if (s_hs !== (n == int'(HA + HFP + 1))) begin
          failures++;
          $display("FAIL restart_hs_small n=%0d got=%b required=%b", n, s_hs,
                   n == int'(HA + HFP + 1));
        end
      end
      if (n == 657 || n == 658) begin
        checks++;
        if (f_hs !== (n == 657)) begin
          failures++;
          $display("FAIL restart_hs_full n=%0d got=%b required=%b", n, f_hs, n == 657);
        end
      end
    end
  endtask

  task automatic test_full_line();
    int   first_fall, hs_run, falls;
    logic prev_hs;
    first_fall = -1;
    hs_run = 0;
    falls = 0;
    prev_hs = 1'b1;
    do_reset(10);
    for (int n = 0; n <= 2408; n++) begin
      adv_tick();
      if (prev_hs && !f_hs) begin
        falls++;
        if (falls == 1) begin
          first_fall = n;
          checks++;
          if (n != 658) begin
            failures++;
            $display("FAIL full_hs_first got=%0d required=658", n);
          end
        end else begin
          checks++;
          if (n - first_fall != 800 * (falls - 1)) begin
            failures++;
            $display("FAIL full_hs_period got=%0d required=%0d", n - first_fall, 800 * (falls - 1));
          end
        end
      end
      if (!f_hs) hs_run++;
      else if (hs_run != 0) begin
        checks++;
        if (hs_run != 96) begin
          failures++;
          $display("FAIL full_hs_width got=%0d required=96", hs_run);
        end
        hs_run = 0;
      end
      prev_hs = f_hs;
      if (n == 639) begin
        checks++;
        if ({f_rd, f_col, f_row} !== {1'b1, 9'd319, 8'd0}) begin
          failures++;
          $display("FAIL full_col_max got rd=%b col=%0d row=%0d required 1 319 0", f_rd, f_col,
                   f_row);
        end
      end
      if (n == 640) begin
        checks++;
        if ({f_rd, f_col} !== {1'b0, 9'd319}) begin
          failures++;
          $display("FAIL full_hblank_read got rd=%b col=%0d required 0 319", f_rd, f_col);
        end
      end
      if (n == 641 || n == 642) begin
        checks++;
        if (f_rgb !== ((n == 641) ? 12'h0FA : 12'h000)) begin
          failures++;
          $display("FAIL full_edge_rgb n=%0d got=%h required=%h", n, f_rgb,
                   (n == 641) ? 12'h0FA : 12'h000);
        end
      end
      if (n == 2407 || n == 2408) begin
        checks++;
        if ({f_rgb, f_vb} !== {((n == 2407) ? 12'h12A : 12'h13A), 1'b0}) begin
          failures++;
          $display("FAIL full_pixel n=%0d got rgb=%h vb=%b required %h 0", n, f_rgb, f_vb,
                   (n == 2407) ? 12'h12A : 12'h13A);
        end
      end
    end
    checks++;
    if (falls != 3) begin
      failures++;
      $display("FAIL full_hs_count got=%0d required=3", falls);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_pixel();
    test_boundary();
    test_mid_reset();
    test_full_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
